uart_rx: RTL

Asynchronous serial receiver, 8N1, LSB first. Oversamples the raw `rx` pin with the system clock and delivers each received byte as `rx_data` with a one-cycle `rx_data_fresh` strobe. It sits directly upstream of the UART reset/command stage, which consumes `rx_data`/`rx_data_fresh`. It also flags framing errors and recovers cleanly from glitches and break conditions.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock.
// Delivers each byte with a one-cycle fresh strobe and flags bad stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_fresh,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          sync1_q, sync2_q;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic          fresh_q, fresh_d;
  logic          err_q, err_d;
  logic          rx_s;
  logic          cnt_full_s;

  assign rx_s       = sync2_q;
  assign cnt_full_s = (cnt_q == FULL_LAST);

  // The synchronizer flops reset high, so rx_s only reflects the real line two
  // cycles after reset; starts are armed only once a genuine high has been seen.
  assign settle_d = {settle_q[0], 1'b1};
  assign armed_d  = armed_q | (settle_q[1] & rx_s);

  // State register, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      idx_q    <= 3'd0;
      sh_q     <= 8'h00;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
      data_q   <= 8'h00;
      fresh_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      settle_q <= settle_d;
      armed_q  <= armed_d;
      data_q   <= data_d;
      fresh_q  <= fresh_d;
      err_q    <= err_d;
    end
  end

  // Next-state, bit timing and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (!rx_s && armed_q) state_d = S_START;
        else                  state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CW{1'b0}};
          idx_d = 3'd0;
          if (rx_s) state_d = S_IDLE;
          else      state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_full_s) begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = {CW{1'b0}};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_full_s) begin
          cnt_d = {CW{1'b0}};
          if (rx_s) state_d = S_IDLE;
          else      state_d = S_BREAK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        cnt_d = {CW{1'b0}};
        if (rx_s) state_d = S_IDLE;
        else      state_d = S_BREAK;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output strobes and byte capture, decided on the stop-bit sample.
  always_comb begin
    data_d  = data_q;
    fresh_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_STOP && cnt_full_s) begin
      if (rx_s) begin
        data_d  = sh_q;
        fresh_d = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_fresh = fresh_q;
  assign rx_frame_err  = err_q;

endmodule
